mac_conventional_driver: RTL
============================

// Module: mac_conventional_driver
// PURPOSE
//   Operand sequencer/initiator for top_mac_conventional. Accepts a stream of (w,a) pairs over
//   valid/ready and applies the per-job precision masking. Drives w/a/rst/accu_rst into the MAC
//   for cfg_len beats, waits out the MAC pipeline, then returns the accumulated z on a
//   valid/ready result port. Sits between the operand buffer and the MAC array.
// PARAMETERS
//   W_WIDTH     8   weight width (signed)
//   A_WIDTH     8   activation width (unsigned)
//   PLUS_WIDTH  4   accumulator headroom; Z_WIDTH = W_WIDTH+A_WIDTH+PLUS_WIDTH (localparam)
//   LEN_WIDTH   10  width of beat-count field
//   MAC_LAT     2   edges from MAC w/a sampling to z including that product
// PORTS
//   clk           in   1          clock
//   rst_n         in   1          async active-low reset
//   start         in   1          job request; sampled only in IDLE
//   cfg_w_mode    in   2          0: W_WIDTH, 1: W_WIDTH/2, 2: W_WIDTH/4 MSBs kept; 3 = 0
//   cfg_a_mode    in   2          same encoding for activations
//   cfg_len       in   LEN_WIDTH  beats per job; 0 means start is ignored
//   busy          out  1          high in every state except IDLE
//   in_valid      in   1          operand beat valid
//   in_ready      out  1          high only in STREAM
//   in_w          in   W_WIDTH    weight, MSB-aligned
//   in_a          in   A_WIDTH    activation, MSB-aligned
//   mac_rst       out  1          MAC rst (active high)
//   mac_accu_rst  out  1          MAC accu_rst
//   mac_w         out  W_WIDTH    MAC w, registered
//   mac_a         out  A_WIDTH    MAC a, registered
//   mac_z         in   Z_WIDTH    MAC z
//   res_valid     out  1          result valid
//   res_ready     in   1          result consumed
//   res_z         out  Z_WIDTH    captured accumulator, held while res_valid
//   res_ovf       out  1          exact sum did not fit Z_WIDTH signed (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, any state):
//     - FSM goes to IDLE. mac_rst=1, mac_accu_rst=1. All other outputs are 0.
//     - mac_rst deasserts on the first clk edge after rst_n rises.
//   FSM:
//     - IDLE: start && cfg_len!=0 -> latch cfg_* and go to CLEAR.
//     - CLEAR: one cycle with mac_accu_rst=1 and mac_w=mac_a=0, then STREAM.
//     - STREAM: in_ready=1, mac_accu_rst=0.
//       - A beat is accepted when in_valid&&in_ready. Accepted beats register
//         mac_w=in_w&wmask and mac_a=in_a&amask.
//       - Cycles with no beat register mac_w=mac_a=0 (a zero-product bubble; the sum is unchanged).
//       - Beat counter counts 0..len-1. Accepting beat len-1 -> DRAIN.
//     - DRAIN: mac_w=mac_a=0 for MAC_LAT+1 cycles. On the last DRAIN edge, res_z<=mac_z,
//       res_valid<=1, and go to RESULT.
//     - RESULT: res_valid=1, res_z stable. When res_ready is high: res_valid<=0, mac_accu_rst<=1,
//       go to IDLE.
//   Masks:
//     - wmask = ~0 << (W_WIDTH - W_WIDTH>>mode); amask uses the same rule.
//   Arithmetic:
//     - Products are signed(w) x unsigned(a).
//     - z wraps modulo 2^Z_WIDTH; res_z is that wrapped value.
//   Other rules:
//     - start outside IDLE is ignored (no queueing).
//     - cfg_* are ignored after latching.
//     - in_valid outside STREAM is not accepted.
//     - Latency for back-to-back beats: last accept -> res_valid = MAC_LAT+2 cycles.
// CONFIGURATION
//   MAC_DRV_OVF_EN
//     - Defined: a shadow accumulator of Z_WIDTH+LEN_WIDTH bits sums the masked products.
//       - It clears in CLEAR.
//       - At capture, res_ovf=1 iff the shadow value is outside the signed Z_WIDTH range.
//       - res_ovf is held with res_z.
//     - Not defined: res_ovf is tied to 0 and no shadow logic exists.
// TESTING
//   T1 full precision:
//     - Stimulus: len=3, beats (w=8'hFF, a=8'h02) x3, no bubbles.
//     - Response: res_z=-6 (20'hFFFFA), res_ovf=0.
//   T2 half-W mode:
//     - Stimulus: cfg_w_mode=1, len=1, in_w=8'h37, in_a=8'h11.
//     - Response: mac_w=8'h30, res_z=816.
//   T3 bubbles:
//     - Stimulus: len=4, each beat w=3, a=5; in_valid low 2 cycles between beats.
//     - Response: res_z=60; in_ready low outside STREAM.
//   T4 backpressure:
//     - Stimulus: res_ready low 5 cycles; pulse start during RESULT.
//     - Response: res_z/res_valid hold; start ignored; IDLE after handshake.
//   T5 reset mid-stream:
//     - Stimulus: rst_n low after beat 2 of len=10.
//     - Response: all outputs 0 (mac_rst=1) immediately. The next job with len=1, w=2, a=3
//       gives res_z=6.
//   T6 overflow:
//     - Stimulus: len=32, w=8'h80, a=8'hFF.
//     - Response: res_z=20'h01000 (wrapped). res_ovf=1 with MAC_DRV_OVF_EN, 0 without.

Source files
------------

// File: rtl/mac_conventional_driver.sv
// rtl/mac_conventional_driver.sv - operand sequencer and result capture for the conventional MAC array
// Optional build macro MAC_DRV_OVF_EN adds a wide shadow accumulator that flags results not fitting Z_WIDTH signed.
module mac_conventional_driver #(
  parameter int W_WIDTH    = 8,
  parameter int A_WIDTH    = 8,
  parameter int PLUS_WIDTH = 4,
  parameter int LEN_WIDTH  = 10,
  parameter int MAC_LAT    = 2,
  localparam int Z_WIDTH   = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cfg_w_mode,
  input  logic [1:0]           cfg_a_mode,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_WIDTH-1:0]   in_w,
  input  logic [A_WIDTH-1:0]   in_a,
  output logic                 mac_rst,
  output logic                 mac_accu_rst,
  output logic [W_WIDTH-1:0]   mac_w,
  output logic [A_WIDTH-1:0]   mac_a,
  input  logic [Z_WIDTH-1:0]   mac_z,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [Z_WIDTH-1:0]   res_z,
  output logic                 res_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RESULT} state_t;

  function automatic logic [W_WIDTH-1:0] wmask_f(input logic [1:0] mode);
    if (mode == 2'd3) return '0;
    else return {W_WIDTH{1'b1}} << (W_WIDTH - (W_WIDTH >> mode));
  endfunction

  function automatic logic [A_WIDTH-1:0] amask_f(input logic [1:0] mode);
    if (mode == 2'd3) return '0;
    else return {A_WIDTH{1'b1}} << (A_WIDTH - (A_WIDTH >> mode));
  endfunction

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [W_WIDTH-1:0]   wmask_q, wmask_d;
  logic [A_WIDTH-1:0]   amask_q, amask_d;
  logic                 mac_rst_q, mac_rst_d;
  logic                 mac_accu_rst_q, mac_accu_rst_d;
  logic [W_WIDTH-1:0]   mac_w_q, mac_w_d;
  logic [A_WIDTH-1:0]   mac_a_q, mac_a_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_q, in_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [Z_WIDTH-1:0]   res_z_q, res_z_d;

  logic                 accept;
  logic                 capture;
  logic [W_WIDTH-1:0]   w_m;
  logic [A_WIDTH-1:0]   a_m;

  assign accept  = (state_q == S_STREAM) && in_valid && in_ready_q;
  // The drain counter reuses cnt_q; MAC_LAT+1 bubble cycles flush the MAC pipeline.
  assign capture = (state_q == S_DRAIN) && (cnt_q == LEN_WIDTH'(MAC_LAT));
  assign w_m     = in_w & wmask_q;
  assign a_m     = in_a & amask_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wmask_d     = wmask_q;
    amask_d     = amask_q;
    res_valid_d = res_valid_q;
    res_z_d     = res_z_q;
    mac_rst_d   = 1'b0;
    mac_w_d     = '0;
    mac_a_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (start && (cfg_len != '0)) begin
          len_d   = cfg_len;
          wmask_d = wmask_f(cfg_w_mode);
          amask_d = amask_f(cfg_a_mode);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          mac_w_d = w_m;
          mac_a_d = a_m;
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (capture) begin
          res_z_d     = mac_z;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d         = (state_d != S_IDLE);
    in_ready_d     = (state_d == S_STREAM);
    mac_accu_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      wmask_q        <= '0;
      amask_q        <= '0;
      mac_rst_q      <= 1'b1;
      mac_accu_rst_q <= 1'b1;
      mac_w_q        <= '0;
      mac_a_q        <= '0;
      busy_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      res_valid_q    <= 1'b0;
      res_z_q        <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      wmask_q        <= wmask_d;
      amask_q        <= amask_d;
      mac_rst_q      <= mac_rst_d;
      mac_accu_rst_q <= mac_accu_rst_d;
      mac_w_q        <= mac_w_d;
      mac_a_q        <= mac_a_d;
      busy_q         <= busy_d;
      in_ready_q     <= in_ready_d;
      res_valid_q    <= res_valid_d;
      res_z_q        <= res_z_d;
    end
  end

  assign busy         = busy_q;
  assign in_ready     = in_ready_q;
  assign mac_rst      = mac_rst_q;
  assign mac_accu_rst = mac_accu_rst_q;
  assign mac_w        = mac_w_q;
  assign mac_a        = mac_a_q;
  assign res_valid    = res_valid_q;
  assign res_z        = res_z_q;

`ifdef MAC_DRV_OVF_EN
  localparam int S_WIDTH = Z_WIDTH + LEN_WIDTH;

  logic signed [W_WIDTH+A_WIDTH:0] prod;
  logic signed [S_WIDTH-1:0]       shadow_q, shadow_d;
  logic [LEN_WIDTH:0]              shadow_top;
  logic                            res_ovf_q, res_ovf_d;

  assign prod = $signed({{(A_WIDTH+1){w_m[W_WIDTH-1]}}, w_m}) *
                $signed({{(W_WIDTH+1){1'b0}}, a_m});
  // Fits Z_WIDTH signed only when every bit above the Z sign bit copies it.
  assign shadow_top = shadow_q[S_WIDTH-1:Z_WIDTH-1];

  always_comb begin
    shadow_d  = shadow_q;
    res_ovf_d = res_ovf_q;
    if (state_q == S_CLEAR) shadow_d = '0;
    else if (accept) shadow_d = shadow_q + S_WIDTH'(prod);
    if (capture) res_ovf_d = !((&shadow_top) || (~|shadow_top));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign res_ovf = res_ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

endmodule
